pipe_stage_reg: RTL and testbench
=================================

// Module: pipe_stage_reg
// PURPOSE
//  Generic parametrised pipeline boundary register between two CPU stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
//  - Captures an opaque payload plus a valid bit from the upstream stage.
//  - Decodes its slice of the global stall vector to advance, hold or insert a bubble.
//  - Supports a flush for exception/branch squash.
//  - Carries multi-cycle scratch state (e.g. madd/msub hi/lo accumulator and step counter) across stalled cycles.
// PARAMETERS
//  DATA_W   64    payload width in bits (packed stage fields, upstream concatenates)
//  NOP_VAL  0     payload value driven on reset, flush or bubble (DATA_W bits)
//  STALL_W  6     width of global stall vector
//  STAGE    3     index of this register's upstream stage in stall; STAGE+1 <= STALL_W-1
//  MC_W     64    multi-cycle scratch width
//  CNT_W    2     multi-cycle step counter width
//  PERF_W   16    perf counter width (used only with PIPE_STAGE_PERF_EN)
// PORTS
//  clk        in   1        clock, all state updates on posedge
//  rst        in   1        reset, synchronous, active-high
//  stall      in   STALL_W  global stall vector, 1 = stage stopped
//  flush      in   1        squash request, 1 = discard payload this edge
//  in_valid   in   1        upstream payload valid
//  in_data    in   DATA_W   upstream payload
//  mc_tmp_i   in   MC_W     scratch from upstream functional unit
//  mc_cnt_i   in   CNT_W    step counter from upstream functional unit
//  out_valid  out  1        registered valid to downstream
//  out_data   out  DATA_W   registered payload to downstream
//  mc_tmp_o   out  MC_W     registered scratch fed back upstream
//  mc_cnt_o   out  CNT_W    registered step counter fed back upstream
//  stall_err  out  1        registered flag: previous edge saw non-monotonic stall (stall[S]=0, stall[S+1]=1)
//  perf_stall out  PERF_W   hold+bubble cycle count (only with PIPE_STAGE_PERF_EN)
//  perf_flush out  PERF_W   flush count (only with PIPE_STAGE_PERF_EN)
// BEHAVIOUR
//  - All outputs are registered. Latency in->out is 1 cycle. There are no combinational paths.
//  - Per-edge priority. Let S = stall[STAGE] and D = stall[STAGE+1].
//   1 rst:    out_valid=0, out_data=NOP_VAL, mc_*_o=0, stall_err=0, perf_*=0.
//   2 flush:  out_valid=0, out_data=NOP_VAL, mc_*_o=0. Flush overrides any stall.
//   3 bubble (S=1, D=0): out_valid=0, out_data=NOP_VAL; mc_tmp_o<=mc_tmp_i, mc_cnt_o<=mc_cnt_i.
//   4 advance (S=0, D=0): out_valid<=in_valid, out_data<=in_data, mc_*_o<=0.
//   5 hold (D=1, any S): out_* keep their values; mc_tmp_o<=mc_tmp_i, mc_cnt_o<=mc_cnt_i.
//  - Non-monotonic stall (S=0, D=1) is treated as hold, so an unconsumed downstream payload is never overwritten.
//    stall_err is set to 1 for that edge and cleared to 0 on any other edge.
//  - in_valid=0 on advance: out_data still captures in_data, out_valid=0.
//  - The scratch path never wraps or saturates; it is a plain copy.
//  - Reset asserted mid multi-cycle op: scratch is cleared and the op restarts from cnt=0.
//  - flush and rst asserted together: rst wins (identical outputs, perf cleared).
// CONFIGURATION
//  - PIPE_STAGE_PERF_EN defined:
//    - perf_stall increments on every bubble or hold edge.
//    - perf_flush increments on every flush edge.
//    - Both saturate at all-ones and are cleared only by rst.
//  - PIPE_STAGE_PERF_EN undefined: both ports are tied to 0 and no counter flops are inferred.
// STRUCTURE
//  - defines.v holds: Stop/NoStop, RstEnable, ZeroWord, NOP payload encodings per stage.
//  - One sub-module, pipe_stall_dec: maps (stall, flush, rst) to a one-hot {rst, flush, bubble, adv, hold}.
//    It also produces the stall_err term. It is combinational and instantiated once.
//  - The top module holds the payload, scratch and perf registers.
// TESTING
//  - T1: rst=1 for 2 cycles -> out_valid=0, out_data=NOP_VAL, mc_cnt_o=0, perf_*=0.
//  - T2: stall=6'b000000, in_data=64'hDEAD_BEEF_0000_0001, in_valid=1 -> next cycle out_data equals in_data, out_valid=1.
//  - T3: stall=6'b001111, mc_cnt_i=2'b01 -> out_valid=0, out_data=NOP_VAL, mc_cnt_o=2'b01. Then mc_cnt_i=2'b10 -> mc_cnt_o=2'b10.
//  - T4: load payload A, then stall=6'b011111 for 3 cycles -> out_data holds A, out_valid stays 1, perf_stall=3.
//  - T5: flush=1 together with stall=6'b011111 -> out_valid=0, out_data=NOP_VAL, mc_*_o=0, perf_flush=1.
//  - T6: stall=6'b010000 with payload A held -> out_data still A, stall_err=1 next cycle. Then stall=0 -> stall_err=0.

Source files
------------

// File: rtl/pipe_stage_reg_pkg.sv
// Shared encodings for the pipeline boundary registers: stall/reset levels,
// the zero word, per-stage NOP payloads and the one-hot stage action.
package pipe_stage_reg_pkg;

    // Stall vector levels: 1 = stage stopped.
    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    // Reset level for the existing codebase (synchronous, active-high).
    localparam logic RST_ENABLE = 1'b1;

    localparam logic [63:0] ZERO_WORD = 64'h0;

    // NOP payload encodings per stage boundary (all-zero packed fields decode
    // as a harmless "no instruction" in every downstream stage).
    localparam logic [63:0] NOP_IF_ID  = ZERO_WORD;
    localparam logic [63:0] NOP_ID_EX  = ZERO_WORD;
    localparam logic [63:0] NOP_EX_MEM = ZERO_WORD;
    localparam logic [63:0] NOP_MEM_WB = ZERO_WORD;

    // One-hot action taken by a boundary register on a given edge.
    typedef enum logic [4:0] {
        OP_RST    = 5'b10000,
        OP_FLUSH  = 5'b01000,
        OP_BUBBLE = 5'b00100,
        OP_ADV    = 5'b00010,
        OP_HOLD   = 5'b00001
    } stage_op_e;

endpackage

// File: rtl/pipe_stall_dec.sv
// Stall decoder: maps (rst, flush, own stall bit, downstream stall bit) onto a
// one-hot stage action and flags non-monotonic stall patterns.
// Purely combinational.
module pipe_stall_dec
    import pipe_stage_reg_pkg::*;
(
    input  logic      rst,
    input  logic      flush,
    input  logic      stall_s,    // stall bit of this register's upstream stage
    input  logic      stall_d,    // stall bit of the downstream stage
    output stage_op_e op,
    output logic      stall_err
);

    // Priority decode: rst > flush > hold (downstream stopped) > bubble > advance.
    // NOTE: every output gets a default before any branch, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        op        = OP_HOLD;
        stall_err = 1'b0;
        if (rst == RST_ENABLE) begin
            op = OP_RST;
        end else begin
            // Upstream running while downstream is stopped: treated as hold
            // below, but reported so the stall generator can be debugged.
            stall_err = (stall_s == NO_STOP) && (stall_d == STOP);
            if (flush) begin
                op = OP_FLUSH;
            end else if (stall_d == STOP) begin
                op = OP_HOLD;
            end else if (stall_s == STOP) begin
                op = OP_BUBBLE;
            end else begin
                op = OP_ADV;
            end
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline boundary register between two CPU stages. Holds the registered
// payload/valid, the multi-cycle scratch (accumulator + step counter) fed back
// upstream, the stall_err flag and, optionally, performance counters.
// Optional feature: define PIPE_STAGE_PERF_EN to build the saturating
// perf_stall / perf_flush counters; otherwise both ports are tied to zero.
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int                DATA_W  = 64,
    parameter logic [DATA_W-1:0] NOP_VAL = '0,
    parameter int                STALL_W = 6,
    parameter int                STAGE   = 3,
    parameter int                MC_W    = 64,
    parameter int                CNT_W   = 2,
    parameter int                PERF_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [STALL_W-1:0] stall,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic [MC_W-1:0]   mc_tmp_i,
    input  logic [CNT_W-1:0]  mc_cnt_i,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [MC_W-1:0]   mc_tmp_o,
    output logic [CNT_W-1:0]  mc_cnt_o,
    output logic              stall_err,
    output logic [PERF_W-1:0] perf_stall,
    output logic [PERF_W-1:0] perf_flush
);

    stage_op_e op;
    logic      stall_err_d;

    // Only two bits of the global stall vector concern this register.
    logic unused_stall;
    assign unused_stall = ^stall;

    pipe_stall_dec u_dec (
        .rst       (rst),
        .flush     (flush),
        .stall_s   (stall[STAGE]),
        .stall_d   (stall[STAGE+1]),
        .op        (op),
        .stall_err (stall_err_d)
    );

    logic              out_valid_d, out_valid_q;
    logic [DATA_W-1:0] out_data_d,  out_data_q;
    logic [MC_W-1:0]   mc_tmp_d,    mc_tmp_q;
    logic [CNT_W-1:0]  mc_cnt_d,    mc_cnt_q;
    logic              stall_err_q;

    // Next payload and scratch state; reset is folded in here because the
    // codebase uses a synchronous reset.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        mc_tmp_d    = mc_tmp_q;
        mc_cnt_d    = mc_cnt_q;
        unique case (op)
            OP_RST, OP_FLUSH: begin
                out_valid_d = 1'b0;
                out_data_d  = NOP_VAL;
                mc_tmp_d    = '0;
                mc_cnt_d    = '0;
            end
            OP_BUBBLE: begin
                out_valid_d = 1'b0;
                out_data_d  = NOP_VAL;
                mc_tmp_d    = mc_tmp_i;
                mc_cnt_d    = mc_cnt_i;
            end
            OP_ADV: begin
                out_valid_d = in_valid;
                out_data_d  = in_data;
                mc_tmp_d    = '0;
                mc_cnt_d    = '0;
            end
            OP_HOLD: begin
                mc_tmp_d    = mc_tmp_i;
                mc_cnt_d    = mc_cnt_i;
            end
            default: ;
        endcase
    end

    // State registers: plain copies of the computed next state.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before the edge.
    always_ff @(posedge clk) begin
        out_valid_q <= out_valid_d;
        out_data_q  <= out_data_d;
        mc_tmp_q    <= mc_tmp_d;
        mc_cnt_q    <= mc_cnt_d;
        stall_err_q <= stall_err_d;
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign mc_tmp_o  = mc_tmp_q;
    assign mc_cnt_o  = mc_cnt_q;
    assign stall_err = stall_err_q;

`ifdef PIPE_STAGE_PERF_EN
    logic [PERF_W-1:0] perf_stall_d, perf_stall_q;
    logic [PERF_W-1:0] perf_flush_d, perf_flush_q;

    // Saturating event counters, cleared only by reset.
    always_comb begin
        perf_stall_d = perf_stall_q;
        perf_flush_d = perf_flush_q;
        if (op == OP_RST) begin
            perf_stall_d = '0;
            perf_flush_d = '0;
        end else begin
            if ((op == OP_BUBBLE || op == OP_HOLD) && perf_stall_q != '1) begin
                perf_stall_d = perf_stall_q + PERF_W'(1);
            end
            if (op == OP_FLUSH && perf_flush_q != '1) begin
                perf_flush_d = perf_flush_q + PERF_W'(1);
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        perf_stall_q <= perf_stall_d;
        perf_flush_q <= perf_flush_d;
    end

    assign perf_stall = perf_stall_q;
    assign perf_flush = perf_flush_q;
`else
    assign perf_stall = '0;
    assign perf_flush = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: a directed vector table covering
// reset, advance, bubble, hold, flush, non-monotonic stall and reset during a
// multi-cycle op, followed by random stimulus against a reference model.
module tb_pipe_stage_reg;

    localparam int          DATA_W  = 64;
    localparam logic [63:0] NOP_VAL = 64'h0;
    localparam int          STALL_W = 6;
    localparam int          STAGE   = 3;
    localparam int          MC_W    = 64;
    localparam int          CNT_W   = 2;
    localparam int          PERF_W  = 4;   // small so saturation is reachable

    logic               clk = 1'b0;
    logic               rst;
    logic [STALL_W-1:0] stall;
    logic               flush;
    logic               in_valid;
    logic [DATA_W-1:0]  in_data;
    logic [MC_W-1:0]    mc_tmp_i;
    logic [CNT_W-1:0]   mc_cnt_i;
    logic               out_valid;
    logic [DATA_W-1:0]  out_data;
    logic [MC_W-1:0]    mc_tmp_o;
    logic [CNT_W-1:0]   mc_cnt_o;
    logic               stall_err;
    logic [PERF_W-1:0]  perf_stall;
    logic [PERF_W-1:0]  perf_flush;

    always #5 clk = ~clk;

    pipe_stage_reg #(
        .DATA_W (DATA_W), .NOP_VAL (NOP_VAL), .STALL_W (STALL_W), .STAGE (STAGE),
        .MC_W (MC_W), .CNT_W (CNT_W), .PERF_W (PERF_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .mc_tmp_i   (mc_tmp_i),
        .mc_cnt_i   (mc_cnt_i),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .mc_tmp_o   (mc_tmp_o),
        .mc_cnt_o   (mc_cnt_o),
        .stall_err  (stall_err),
        .perf_stall (perf_stall),
        .perf_flush (perf_flush)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic        valid;
        logic [63:0] data;
        logic [63:0] tmp;
        logic [1:0]  cnt;
        logic        err;
        int          ps;
        int          pf;
    } model_t;

    model_t mdl;

    // Outcome of one edge, worked out from the behavioural rules directly.
    function automatic model_t model_step(input model_t m, input logic r, input logic f,
                                          input logic [5:0] st, input logic iv,
                                          input logic [63:0] id, input logic [63:0] ti,
                                          input logic [1:0] ci);
        model_t n = m;
        bit s = st[STAGE];
        bit d = st[STAGE+1];
        int perf_max = (1 << PERF_W) - 1;
        if (r) begin
            n = '{valid: 1'b0, data: NOP_VAL, tmp: 64'h0, cnt: 2'b0, err: 1'b0, ps: 0, pf: 0};
            return n;
        end
        n.err = (!s && d);
        if (f) begin
            n.valid = 0; n.data = NOP_VAL; n.tmp = 0; n.cnt = 0;
            n.pf = (m.pf < perf_max) ? m.pf + 1 : perf_max;
        end else if (d || s) begin
            // hold when downstream stopped, else bubble; scratch copied either way
            if (!d) begin n.valid = 0; n.data = NOP_VAL; end
            n.tmp = ti; n.cnt = ci;
            n.ps = (m.ps < perf_max) ? m.ps + 1 : perf_max;
        end else begin
            n.valid = iv; n.data = id; n.tmp = 0; n.cnt = 0;
        end
        return n;
    endfunction

    task automatic drive_and_clock(input logic r, input logic f, input logic [5:0] st,
                                   input logic iv, input logic [63:0] id,
                                   input logic [63:0] ti, input logic [1:0] ci);
        model_t nxt;
        rst = r; flush = f; stall = st; in_valid = iv; in_data = id;
        mc_tmp_i = ti; mc_cnt_i = ci;
        nxt = model_step(mdl, r, f, st, iv, id, ti, ci);
        @(posedge clk);
        #1;
        mdl = nxt;
    endtask

    function automatic logic [63:0] exp_perf(input int v);
`ifdef PIPE_STAGE_PERF_EN
        return 64'(v);
`else
        return 64'(v & 0);
`endif
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        r, f;
        logic [5:0]  st;
        logic        iv;
        logic [63:0] id, ti;
        logic [1:0]  ci;
        logic        e_valid;
        logic [63:0] e_data, e_tmp;
        logic [1:0]  e_cnt;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];

    localparam logic [63:0] A  = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] B  = 64'hFEED_0000_1234_5678;
    localparam logic [63:0] T  = 64'hAAAA_5555_0F0F_F0F0;
    localparam logic [63:0] T2 = 64'h5555_AAAA_F0F0_0F0F;
    localparam logic [63:0] DB = 64'hDEAD_BEEF_0000_0001;

    initial begin
        // reset for two cycles
        vecs.push_back('{1,0,6'b000000,1,A, T,2'd3, 0,NOP_VAL,64'h0,2'd0,0});
        vecs.push_back('{1,0,6'b000000,1,A, T,2'd3, 0,NOP_VAL,64'h0,2'd0,0});
        // advance; scratch cleared
        vecs.push_back('{0,0,6'b000000,1,DB,T,2'd3, 1,DB,     64'h0,2'd0,0});
        // bubble: scratch copied each cycle
        vecs.push_back('{0,0,6'b001111,1,B, T,2'd1, 0,NOP_VAL,T,    2'd1,0});
        vecs.push_back('{0,0,6'b001111,1,B, T2,2'd2,0,NOP_VAL,T2,   2'd2,0});
        // load A, then hold three cycles
        vecs.push_back('{0,0,6'b000000,1,A, T,2'd3, 1,A,      64'h0,2'd0,0});
        vecs.push_back('{0,0,6'b011111,1,B, T,2'd1, 1,A,      T,    2'd1,0});
        vecs.push_back('{0,0,6'b011111,1,B, T,2'd2, 1,A,      T,    2'd2,0});
        vecs.push_back('{0,0,6'b011111,1,B, T,2'd3, 1,A,      T,    2'd3,0});
        // flush beats stall
        vecs.push_back('{0,1,6'b011111,1,B, T,2'd3, 0,NOP_VAL,64'h0,2'd0,0});
        // non-monotonic stall holds A and raises stall_err, then clears
        vecs.push_back('{0,0,6'b000000,1,A, T,2'd0, 1,A,      64'h0,2'd0,0});
        vecs.push_back('{0,0,6'b010000,1,B, T,2'd2, 1,A,      T,    2'd2,1});
        // advance with in_valid=0 still captures data
        vecs.push_back('{0,0,6'b000000,0,B, T,2'd2, 0,B,      64'h0,2'd0,0});
        // rst and flush together
        vecs.push_back('{1,1,6'b011111,1,A, T,2'd3, 0,NOP_VAL,64'h0,2'd0,0});
        // reset mid multi-cycle op, then restart from cnt=0
        vecs.push_back('{0,0,6'b001111,1,A, T,2'd3, 0,NOP_VAL,T,    2'd3,0});
        vecs.push_back('{1,0,6'b001111,1,A, T,2'd3, 0,NOP_VAL,64'h0,2'd0,0});
        vecs.push_back('{0,0,6'b001111,1,A, T,2'd0, 0,NOP_VAL,T,    2'd0,0});

        mdl = '{valid: 1'b0, data: NOP_VAL, tmp: 64'h0, cnt: 2'b0, err: 1'b0, ps: 0, pf: 0};

        foreach (vecs[i]) begin
            vec_t v = vecs[i];
            drive_and_clock(v.r, v.f, v.st, v.iv, v.id, v.ti, v.ci);
            check($sformatf("v%0d out_valid", i), 64'(out_valid), 64'(v.e_valid));
            check($sformatf("v%0d out_data", i),  out_data,        v.e_data);
            check($sformatf("v%0d mc_tmp_o", i),  mc_tmp_o,        v.e_tmp);
            check($sformatf("v%0d mc_cnt_o", i),  64'(mc_cnt_o),  64'(v.e_cnt));
            check($sformatf("v%0d stall_err", i), 64'(stall_err), 64'(v.e_err));
            check($sformatf("v%0d perf_stall", i), 64'(perf_stall), exp_perf(mdl.ps));
            check($sformatf("v%0d perf_flush", i), 64'(perf_flush), exp_perf(mdl.pf));
        end

        // Long hold run drives perf_stall into saturation when enabled.
        for (int i = 0; i < 20; i++) begin
            drive_and_clock(0, 0, 6'b011111, 1, B, T, 2'(i));
        end
        check("sat perf_stall", 64'(perf_stall), exp_perf(mdl.ps));
        check("sat out_data", out_data, mdl.data);

        // ---------------- random phase ----------------
        for (int i = 0; i < 400; i++) begin
            logic r, f, iv;
            logic [5:0] st;
            r  = ($urandom_range(0, 31) == 0);
            f  = ($urandom_range(0, 11) == 0);
            st = 6'($urandom);
            iv = 1'($urandom);
            drive_and_clock(r, f, st, iv, {$urandom, $urandom}, {$urandom, $urandom},
                            2'($urandom));
            check($sformatf("r%0d out_valid", i), 64'(out_valid), 64'(mdl.valid));
            check($sformatf("r%0d out_data", i),  out_data,        mdl.data);
            check($sformatf("r%0d mc_tmp_o", i),  mc_tmp_o,        mdl.tmp);
            check($sformatf("r%0d mc_cnt_o", i),  64'(mc_cnt_o),  64'(mdl.cnt));
            check($sformatf("r%0d stall_err", i), 64'(stall_err), 64'(mdl.err));
            check($sformatf("r%0d perf_stall", i), 64'(perf_stall), exp_perf(mdl.ps));
            check($sformatf("r%0d perf_flush", i), 64'(perf_flush), exp_perf(mdl.pf));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
